sd_cmd_engine: RTL
==================

// Module: sd_cmd_engine
// PURPOSE
// - Downstream consumer of the host register file. Takes Argument, cmd_index and response
//   type, serialises a 48-bit SD command frame on the CMD line and captures the card response.
// - Response is returned to the register file together with completion/error strobes
//   (written into Response0..7 and the interrupt status regs).
// - Bit timing comes from an sd_tick enable; everything runs in the single clk domain.
// PARAMETERS
// - TO_W  16  width of timeout_val and the response-wait counter (units: sd_tick)
// PORTS
// - clk           in   1    system clock
// - reset         in   1    synchronous, active-high reset
// - sd_tick       in   1    1-cycle strobe; one CMD-line bit per tick
// - start         in   1    1-cycle request to issue a command; ignored while busy=1
// - cmd_index     in   6    command index (Command[13:8])
// - argument      in   32   command argument
// - resp_type     in   2    00 none, 01 R2 (136 bit), 10 48 bit, 11 48 bit (busy not checked)
// - timeout_val   in   TO_W max ticks from end bit to response start bit
// - cmd_in        in   1    CMD line input (from pad)
// - cmd_out       out  1    CMD line output value
// - cmd_oe        out  1    CMD line output enable
// - busy          out  1    high from accepted start until the done pulse
// - response      out  128  captured response, valid when done=1
// - done          out  1    1-cycle completion pulse (with or without error)
// - timeout_err   out  1    valid with done
// - crc_err       out  1    valid with done
// - index_err     out  1    valid with done
// BEHAVIOUR
// - Reset values: cmd_out=1, cmd_oe=0, busy=0, response=0, done=0, all err=0, state IDLE.
//   Reset mid-operation aborts immediately. No done pulse.
// - Start handling: start is sampled in IDLE only. The block latches index, argument, type and
//   timeout, sets busy next cycle and goes to SEND.
// - SEND: frame = {0,1,index[5:0],arg[31:0],crc7[6:0],1}, MSB first, one bit per sd_tick,
//   cmd_oe=1. CRC7 uses poly x^7+x^3+1, init 0, over the first 40 bits.
// - After the end bit: cmd_oe=0 and cmd_out=1. If resp_type=00, go to DONE; else go to WAIT.
// - WAIT: on each tick, cmd_in==0 means a start bit, so go to RECV (counting it as bit 1).
//   Otherwise increment the counter. When the counter reaches timeout_val, set timeout_err and
//   go to DONE. timeout_val=0 times out on the first tick without a start bit.
// - RECV: shift cmd_in on ticks until 48 bits (R1/R3/R6/R7) or 136 bits (R2) are in.
//   - 48-bit: response[31:0] = bits[39:8], response[127:32] = 0.
//     index_err if bits[45:40] != cmd_index.
//     crc_err if CRC7 over bits[47:8] != bits[7:1] or the end bit != 1.
//   - 136-bit: response[119:0] = bits[127:8], response[127:120] = 0. No index check.
//     CRC7 is checked over bits[127:8] (excluding the 8 header bits).
// - DONE: lasts one cycle. done=1, busy=0 on the next cycle, then back to IDLE.
//   Err flags are held until the next accepted start.
// - Clock gaps: no ticks means no progress. State and counters hold indefinitely.
// - start arriving in the same cycle as done is ignored (state is not yet IDLE).
// STRUCTURE
// - sd_cmd_pkg: state encoding (IDLE, SEND, WAIT, RECV, DONE), resp_type codes,
//   frame lengths (48, 136), CRC7 polynomial constant.
// - Sub-module sd_crc7: serial CRC7 with clr, en and bit_in, and a 7-bit crc output.
//   Instantiated twice (TX and RX), or once time-shared since TX and RX never overlap.
// TESTING
// - CMD0, arg 0, type 00: line shows 0x400000000095, then done with no errors, busy low after.
// - CMD8, arg 0x000001AA, type 10: TX 0x48000001AA87. Card echoes the same 48 bits, so
//   response=0x000001AA and no errors.
// - CMD17, arg 0: TX 0x510000000055. Card replies with a corrupted CRC, so crc_err=1 and done
//   pulses. Reply index 18 instead gives index_err=1.
// - type 10, timeout_val=8, cmd_in held at 1: timeout_err=1 exactly on the 8th tick after the
//   end bit.
// - R2 (type 01): 136-bit reply with a known CID. response[119:0] matches bits[127:8] and
//   crc_err=0.
// - start pulsed during SEND is ignored. Reset asserted in RECV gives cmd_oe=0, busy=0, no done.
//   sd_tick held low for 100 cycles gives no state change.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD command engine: FSM states, response
// type codes, frame lengths and the CRC7 generator polynomial.
package sd_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT,
      ST_RECV,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      RESP_NONE = 2'b00,
      RESP_R2   = 2'b01,
      RESP_48   = 2'b10,
      RESP_48NB = 2'b11
   } resp_e;

   localparam int unsigned CMD_LEN      = 48;
   localparam int unsigned R2_LEN       = 136;
   localparam int unsigned CMD_CRC_BITS = 40;
   localparam int unsigned R2_HDR_BITS  = 8;

   // x^7 + x^3 + 1 with the x^7 term implied
   localparam logic [6:0] CRC7_POLY = 7'h09;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = crc[6] ^ bit_in;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_cmd_if.sv
// Request/response bundle between the host register file (master) and the
// command engine (slave).
interface sd_cmd_if #(
   parameter int unsigned TO_W = 16
);
   logic            start;
   logic [5:0]      cmd_index;
   logic [31:0]     argument;
   logic [1:0]      resp_type;
   logic [TO_W-1:0] timeout_val;
   logic            busy;
   logic [127:0]    response;
   logic            done;
   logic            timeout_err;
   logic            crc_err;
   logic            index_err;

   modport master (
      output start, cmd_index, argument, resp_type, timeout_val,
      input  busy, response, done, timeout_err, crc_err, index_err
   );

   modport slave (
      input  start, cmd_index, argument, resp_type, timeout_val,
      output busy, response, done, timeout_err, crc_err, index_err
   );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clr has priority over en. Shared between the
// transmit and receive phases, which never overlap.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);
   logic [6:0] crc_q;
   logic [6:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = 7'h00;
      end else if (en) begin
         crc_d = crc7_step(crc_q, bit_in);
      end
   end

   always_ff @(posedge clk) begin
      crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command frame, waits for and captures
// the card response (48 or 136 bits), and reports completion and error flags.
module sd_cmd_engine
   import sd_cmd_pkg::*;
#(
   parameter int unsigned TO_W = 16
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    sd_tick,
   input  logic    cmd_in,
   output logic    cmd_out,
   output logic    cmd_oe,
   sd_cmd_if.slave host
);
   localparam logic [7:0] TX_LAST      = 8'(CMD_LEN - 1);
   localparam logic [7:0] TX_CRC_FIRST = 8'(CMD_CRC_BITS);
   localparam logic [7:0] TX_CRC_LAST  = 8'(CMD_LEN - 2);
   localparam logic [7:0] LEN_48       = 8'(CMD_LEN);
   localparam logic [7:0] LEN_R2       = 8'(R2_LEN);
   localparam logic [7:0] R48_CRC_LAST = 8'(CMD_CRC_BITS);
   localparam logic [7:0] R2_CRC_FIRST = 8'(R2_HDR_BITS + 1);
   localparam logic [7:0] R2_CRC_LAST  = 8'(R2_LEN - 8);

   state_e          state_q, state_d;
   logic [5:0]      idx_q, idx_d;
   logic [1:0]      type_q, type_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [TO_W:0]   wait_inc;
   logic [7:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      rx_pos;
   logic [7:0]      frame_len;
   logic [39:0]     tx_sr_q, tx_sr_d;
   logic [126:0]    rx_sr_q, rx_sr_d;
   logic [127:0]    rx_shift;
   logic [127:0]    response_q, response_d;
   logic            terr_q, terr_d;
   logic            cerr_q, cerr_d;
   logic            ierr_q, ierr_d;
   logic            crc_clr, crc_en, crc_bit;
   logic [6:0]      crc_val;
   logic [2:0]      crc_sel;
   logic            is_r2;

   sd_crc7 u_crc7 (
      .clk    (clk),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (crc_bit),
      .crc    (crc_val)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      type_d     = type_q;
      to_d       = to_q;
      wait_cnt_d = wait_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      response_d = response_q;
      terr_d     = terr_q;
      cerr_d     = cerr_q;
      ierr_d     = ierr_q;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_bit    = 1'b0;
      cmd_out    = 1'b1;

      is_r2     = (type_q == RESP_R2);
      frame_len = is_r2 ? LEN_R2 : LEN_48;
      rx_pos    = bit_cnt_q + 8'd1;
      rx_shift  = {rx_sr_q, cmd_in};
      wait_inc  = {1'b0, wait_cnt_q} + {{TO_W{1'b0}}, 1'b1};
      // bit positions 40..46 carry crc[6]..crc[0]
      crc_sel   = 3'(TX_CRC_LAST - bit_cnt_q);

      unique case (state_q)
         ST_IDLE: begin
            if (host.start) begin
               idx_d      = host.cmd_index;
               type_d     = host.resp_type;
               to_d       = host.timeout_val;
               tx_sr_d    = {2'b01, host.cmd_index, host.argument};
               bit_cnt_d  = 8'd0;
               wait_cnt_d = '0;
               response_d = '0;
               terr_d     = 1'b0;
               cerr_d     = 1'b0;
               ierr_d     = 1'b0;
               crc_clr    = 1'b1;
               state_d    = ST_SEND;
            end
         end

         ST_SEND: begin
            if (bit_cnt_q < TX_CRC_FIRST) begin
               cmd_out = tx_sr_q[39];
            end else if (bit_cnt_q <= TX_CRC_LAST) begin
               cmd_out = crc_val[crc_sel];
            end
            if (sd_tick) begin
               bit_cnt_d = bit_cnt_q + 8'd1;
               if (bit_cnt_q < TX_CRC_FIRST) begin
                  crc_en  = 1'b1;
                  crc_bit = tx_sr_q[39];
                  tx_sr_d = {tx_sr_q[38:0], 1'b0};
               end
               if (bit_cnt_q == TX_LAST) begin
                  // TX CRC no longer needed; rearm it for the response
                  bit_cnt_d = 8'd0;
                  crc_clr   = 1'b1;
                  state_d   = (type_q == RESP_NONE) ? ST_DONE : ST_WAIT;
               end
            end
         end

         ST_WAIT: begin
            if (sd_tick) begin
               if (!cmd_in) begin
                  rx_sr_d   = rx_shift[126:0];
                  bit_cnt_d = 8'd1;
                  crc_en    = !is_r2;
                  crc_bit   = cmd_in;
                  state_d   = ST_RECV;
               end else begin
                  wait_cnt_d = wait_inc[TO_W-1:0];
                  if (wait_inc >= {1'b0, to_q}) begin
                     terr_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end
            end
         end

         ST_RECV: begin
            if (sd_tick) begin
               rx_sr_d   = rx_shift[126:0];
               bit_cnt_d = rx_pos;
               crc_bit   = cmd_in;
               // R2 excludes its 8 header bits from the CRC
               crc_en    = is_r2 ? (rx_pos >= R2_CRC_FIRST && rx_pos <= R2_CRC_LAST)
                                 : (rx_pos <= R48_CRC_LAST);
               if (rx_pos == frame_len) begin
                  state_d = ST_DONE;
                  if (is_r2) begin
                     response_d = {8'h00, rx_shift[127:8]};
                     cerr_d     = (crc_val != rx_shift[7:1]);
                  end else begin
                     response_d = {96'h0, rx_shift[39:8]};
                     ierr_d     = (rx_shift[45:40] != idx_q);
                     cerr_d     = (crc_val != rx_shift[7:1]) || !rx_shift[0];
                  end
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         bit_cnt_q  <= 8'd0;
         response_q <= '0;
         terr_q     <= 1'b0;
         cerr_q     <= 1'b0;
         ierr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         response_q <= response_d;
         terr_q     <= terr_d;
         cerr_q     <= cerr_d;
         ierr_q     <= ierr_d;
      end
   end

   // Latched request and shift registers are only read once qualified by state
   always_ff @(posedge clk) begin
      idx_q   <= idx_d;
      type_q  <= type_d;
      to_q    <= to_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
   end

   assign cmd_oe           = (state_q == ST_SEND);
   assign host.busy        = (state_q != ST_IDLE);
   assign host.done        = (state_q == ST_DONE);
   assign host.response    = response_q;
   assign host.timeout_err = terr_q;
   assign host.crc_err     = cerr_q;
   assign host.index_err   = ierr_q;

endmodule
